// File: rtl/uart_rx_frame.sv
// 8-bit UART receiver with optional parity. Reports each completed frame as one
// pulse: UART_data_valid for a clean frame, or UART_errors_valid with {framing, parity}.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] UART_data,
    output logic       UART_data_valid,
    output logic [1:0] UART_errors,
    output logic       UART_errors_valid,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            rx_m              <= 1'b1;
            rx_s              <= 1'b1;
            cnt               <= '0;
            bit_idx           <= '0;
            shift             <= '0;
            perr              <= 1'b0;
            UART_data         <= '0;
            UART_data_valid   <= 1'b0;
            UART_errors       <= '0;
            UART_errors_valid <= 1'b0;
            busy              <= 1'b0;
        end else begin
            rx_m              <= rx;
            rx_s              <= rx_m;
            UART_data_valid   <= 1'b0;
            UART_errors_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            perr    <= 1'b0;
                        end else begin
                            // start bit vanished by mid-bit: line glitch, drop it silently
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        perr  <= ((^shift) ^ rx_s) != PARITY_ODD;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        UART_data <= shift;
                        if (!rx_s || perr) begin
                            UART_errors       <= {~rx_s, perr};
                            UART_errors_valid <= 1'b1;
                        end else begin
                            UART_data_valid <= 1'b1;
                        end
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // break or stuck-low line: hold off until it returns high
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives whole serial frames and compares reported
// pulses against an expected-event queue built from each frame's contents.
module tb_uart_rx_frame;

    localparam int CPB        = 16;
    localparam bit PARITY_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] UART_data;
    logic       UART_data_valid;
    logic [1:0] UART_errors;
    logic       UART_errors_valid;
    logic       busy;

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(PARITY_ODD)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx               (rx),
        .UART_data        (UART_data),
        .UART_data_valid  (UART_data_valid),
        .UART_errors      (UART_errors),
        .UART_errors_valid(UART_errors_valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int overlap = 0;
    int last_pulse_cyc = 0;
    int start_cyc = 0;

    // event word: {is_error, errors[1:0], data[7:0]}
    logic [10:0] evq[$];
    logic [10:0] expq[$];
    logic [7:0]  exp_data;
    logic [1:0]  exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (UART_data_valid && UART_errors_valid) overlap++;
            if (UART_data_valid) begin
                evq.push_back({1'b0, 2'b00, UART_data});
                last_pulse_cyc = cyc;
            end else if (UART_errors_valid) begin
                evq.push_back({1'b1, UART_errors, UART_data});
                last_pulse_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    // Drive one frame and record the outcome the receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_val,
                              input int hold_low, input int gap);
        logic p;
        logic perr;
        logic ferr;
        p = (PARITY_ODD ? ~(^d) : ^d) ^ bad_par;
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        hold(1'b0, CPB - 1);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(p, CPB);
        hold(stop_val, CPB);
        if (!stop_val) hold(1'b0, hold_low);
        hold(1'b1, gap);
        perr = bad_par;
        ferr = ~stop_val;
        exp_data = d;
        if (perr || ferr) begin
            exp_err = {ferr, perr};
            expq.push_back({1'b1, exp_err, d});
        end else begin
            expq.push_back({1'b0, 2'b00, d});
        end
    endtask

    task automatic drain(input string tag);
        hold(1'b1, CPB);
        check({tag, "_count"}, evq.size(), expq.size());
        while (evq.size() > 0 && expq.size() > 0)
            check({tag, "_event"}, int'(evq.pop_front()), int'(expq.pop_front()));
        evq.delete();
        expq.delete();
        check({tag, "_data"}, UART_data, exp_data);
        check({tag, "_errors"}, UART_errors, exp_err);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [7:0] d;
        bit bad;
        bit stopv;
        int hl;
        int gp;

        rst = 1'b1;
        rx  = 1'b1;
        exp_data = '0;
        exp_err  = '0;
        repeat (4) @(negedge clk);
        check("rst_data", UART_data, 0);
        check("rst_dv", UART_data_valid, 0);
        check("rst_err", UART_errors, 0);
        check("rst_ev", UART_errors_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        hold(1'b1, 4);

        // single good frame with latency measurement
        send_frame(8'hDD, 1'b0, 1'b1, 0, 0);
        lat = last_pulse_cyc - start_cyc;
        drain("t1");
        check("t1_latency_in_window", int'(lat >= 170 && lat <= 172), 1);

        // back-to-back frames, no idle gap
        send_frame(8'hD1, 1'b0, 1'b1, 0, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 0, 4);
        drain("t2");

        // parity error
        send_frame(8'hAA, 1'b1, 1'b1, 0, 4);
        drain("t3");

        // framing error with a long low line, then recovery
        send_frame(8'h55, 1'b0, 1'b0, 0, 0);
        hold(1'b0, 64);
        check("t4_busy_low", busy, 1);
        hold(1'b1, 6);
        check("t4_busy_released", busy, 0);
        drain("t4");
        send_frame(8'h3C, 1'b0, 1'b1, 0, 4);
        drain("t4b");

        // short glitch is ignored
        hold(1'b0, 4);
        hold(1'b1, CPB / 2 + 6);
        check("t5_glitch_busy", busy, 0);
        check("t5_glitch_events", evq.size(), 0);
        send_frame(8'h0F, 1'b1, 1'b0, 8, 8);
        drain("t5");

        // reset in the middle of data bit 4
        d = 8'h81;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(d[i], CPB);
        hold(d[4], CPB / 2);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_data", UART_data, 0);
        check("t6_rst_err", UART_errors, 0);
        check("t6_rst_valids", {UART_data_valid, UART_errors_valid}, 0);
        check("t6_rst_busy", busy, 0);
        exp_data = '0;
        exp_err  = '0;
        hold(1'b1, CPB * 12);
        check("t6_no_events", evq.size(), 0);
        send_frame(8'h81, 1'b0, 1'b1, 0, 4);
        drain("t6");

        // randomized frames, drained in groups so some run back-to-back
        for (int i = 0; i < 24; i++) begin
            d     = 8'($urandom);
            bad   = ($urandom_range(3) == 0);
            stopv = ($urandom_range(4) != 0);
            hl    = stopv ? 0 : int'($urandom_range(20));
            gp    = stopv ? int'($urandom_range(10)) : int'($urandom_range(10, 4));
            send_frame(d, bad, stopv, hl, gp);
            if (i % 4 == 3) drain("rnd");
        end

        check("no_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
